lzd_normalizer: RTL and testbench
=================================

// Module: lzd_normalizer
// PURPOSE
//  Pipelined leading-zero normalizer for the Box-Muller AWGN datapath. Takes an
//  unsigned uniform sample, counts its leading zeros and left-shifts it so the MSB
//  is 1, producing (lz_count, mantissa) for the downstream log/sqrt range reduction.
//  Sits between the uniform RNG and the ln() evaluator. Valid/ready on both sides.
// PARAMETERS
//  DATA_W  32  input/mantissa width; power of 2, 8..64
//  CNT_W   $clog2(DATA_W)  lz_count width (derived, not overridden)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       in_data valid
//  in_ready   out  1       stage-1 can accept this cycle
//  in_data    in   DATA_W  unsigned sample
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts
//  out_mant   out  DATA_W  in_data << lz_count (MSB=1 unless out_zero)
//  out_lz     out  CNT_W   number of leading zeros, 0..DATA_W-1
//  out_zero   out  1       in_data was all zeros
// BEHAVIOUR
//  Reset: clock and reset are fixed as one clock, reset asynchronous active-low.
//   Asserting rst_n=0 clears all stage valids immediately;
//   out_valid=0, out_mant=0, out_lz=0, out_zero=0. Data regs reset to 0.
//  Transfer occurs on a side when valid&&ready at a rising edge.
//  Pipeline, 3 register stages, latency 3 cycles from input transfer to out_valid:
//   S1: register in_data.
//   S2: lzd_tree on S1 data -> register lz count, zero flag, data.
//   S3: barrel left shift of S2 data by lz count -> register out_mant/out_lz/out_zero.
//  Per-stage flow control (bubble-collapsing): ready_k = ~valid_k | ready_{k+1};
//   ready_4 = out_ready; in_ready = ready_1. A stage loads only when its ready_k=1;
//   otherwise holds data and valid unchanged. Full throughput 1/cycle when out_ready=1.
//  Output stability: while out_valid=1 && out_ready=0, all out_* held constant.
//  Zero input: out_zero=1, out_lz=0, out_mant=0 (not DATA_W; count never overflows CNT_W).
//  Arithmetic: out_lz = DATA_W-1-floor(log2(in_data)) for in_data!=0; shift is logical,
//   zero-fill LSBs, no bits lost (shift < leading-zero count+1).
//  Ordering: strictly in-order, no drop, no duplicate; max 3 items in flight.
//  Reset mid-operation: all in-flight samples discarded; no partial output after rst_n release;
//   in_ready=1 the first cycle after rst_n deasserts.
//  in_data/in_valid sampled only on handshake; X on in_data with in_valid=0 ignored.
// STRUCTURE
//  Shared package bm_awgn_pkg: URNG_W (=32) default, function clog2, localparam
//   typedef for {zero, lz, mant} result struct used by the ln() stage.
//  One sub-module: lzd_tree #(DATA_W) - combinational recursive leading-zero detector
//   built from 4-bit leaf detectors merged pairwise (valid = OR of halves,
//   count = upper-half-empty ? {1,lower count} : {0,upper count}); outputs lz and all-zero.
//  Shifter inline in S3 as log2(DATA_W) mux levels; no other hierarchy.
// TESTING (DATA_W=32)
//  T1 in 0x0000_0001 -> 3 cycles later out_lz=31, out_mant=0x8000_0000, out_zero=0.
//  T2 in 0x8000_0000, 0x00F0_0000, 0x0001_2345 back-to-back, out_ready=1 -> outputs
//     on consecutive cycles: (0,0x8000_0000), (8,0xF000_0000), (15,0x91A2_8000).
//  T3 in 0x0000_0000 -> out_zero=1, out_lz=0, out_mant=0.
//  T4 backpressure: stream 6 samples, out_ready=0 for 5 cycles -> in_ready drops after
//     3 accepted, out_* stable while stalled, all 6 emerge in order, no loss.
//  T5 reset mid-flight: 2 samples in pipe, pulse rst_n low asynchronously between edges
//     -> out_valid=0 immediately, no stale output after release, next sample latency 3.
//  T6 random 10k samples with random valid/ready vs reference model lz/shift -> exact match.

Source files
------------

// File: rtl/bm_awgn_pkg.sv
// Shared definitions for the Box-Muller AWGN datapath: default sample width,
// a constant-safe clog2 and the normalizer result record consumed by the ln() stage.
package bm_awgn_pkg;

  localparam int URNG_W = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; (1 << i) < value; i++) begin
      r = i + 1;
    end
    return r;
  endfunction

  localparam int URNG_CNT_W = clog2(URNG_W);

  typedef struct packed {
    logic                  zero;
    logic [URNG_CNT_W-1:0] lz;
    logic [URNG_W-1:0]     mant;
  } lzn_result_t;

endpackage

// File: rtl/lzd_tree.sv
// Combinational recursive leading-zero detector: 4-bit leaves merged pairwise,
// reporting the leading-zero count and an all-zero flag.
module lzd_tree
  import bm_awgn_pkg::*;
#(
  parameter  int W  = 32,
  localparam int CW = clog2(W)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] lz,
  output logic          all_zero
);

  if (W == 4) begin : g_leaf
    always_comb begin
      all_zero = ~|data;
      if (data[3])      lz = 2'd0;
      else if (data[2]) lz = 2'd1;
      else if (data[1]) lz = 2'd2;
      else              lz = 2'd3;
    end
  end else begin : g_node
    localparam int HW = W / 2;

    logic [CW-2:0] hi_lz;
    logic [CW-2:0] lo_lz;
    logic          hi_zero;
    logic          lo_zero;

    lzd_tree #(.W(HW)) u_hi (
      .data     (data[W-1:HW]),
      .lz       (hi_lz),
      .all_zero (hi_zero)
    );

    lzd_tree #(.W(HW)) u_lo (
      .data     (data[HW-1:0]),
      .lz       (lo_lz),
      .all_zero (lo_zero)
    );

    // An empty upper half contributes exactly HW zeros, i.e. the new MSB of the count.
    assign all_zero = hi_zero & lo_zero;
    assign lz       = hi_zero ? {1'b1, lo_lz} : {1'b0, hi_lz};
  end

endmodule

// File: rtl/lzd_normalizer.sv
// Three-stage leading-zero normalizer with bubble-collapsing valid/ready:
// S1 captures the sample, S2 counts leading zeros, S3 left-shifts to MSB=1.
module lzd_normalizer
  import bm_awgn_pkg::*;
#(
  parameter  int DATA_W = URNG_W,
  localparam int CNT_W  = clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mant,
  output logic [CNT_W-1:0]  out_lz,
  output logic              out_zero
);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q,  s2_data_d;
  logic [CNT_W-1:0]  s2_lz_q,    s2_lz_d;
  logic              s2_zero_q,  s2_zero_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_mant_q,  out_mant_d;
  logic [CNT_W-1:0]  out_lz_q,    out_lz_d;
  logic              out_zero_q,  out_zero_d;

  logic              ready_1, ready_2, ready_3;
  logic [CNT_W-1:0]  tree_lz;
  logic              tree_zero;
  logic [DATA_W-1:0] shifted;

  // A stage may load when it is empty or its successor is draining this cycle.
  assign ready_3  = ~out_valid_q | out_ready;
  assign ready_2  = ~s2_valid_q  | ready_3;
  assign ready_1  = ~s1_valid_q  | ready_2;
  assign in_ready = ready_1;

  lzd_tree #(.W(DATA_W)) u_lzd (
    .data     (s1_data_q),
    .lz       (tree_lz),
    .all_zero (tree_zero)
  );

  // Barrel shifter: one mux level per count bit.
  always_comb begin
    shifted = s2_data_q;
    for (int k = 0; k < CNT_W; k++) begin
      if (s2_lz_q[k]) shifted = shifted << (1 << k);
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_lz_d     = s2_lz_q;
    s2_zero_d   = s2_zero_q;
    out_valid_d = out_valid_q;
    out_mant_d  = out_mant_q;
    out_lz_d    = out_lz_q;
    out_zero_d  = out_zero_q;

    // Data registers only move with a real sample so idle/X inputs never leak in.
    if (ready_1) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_data_d = in_data;
    end

    if (ready_2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s1_data_q;
        s2_lz_d   = tree_zero ? '0 : tree_lz;
        s2_zero_d = tree_zero;
      end
    end

    if (ready_3) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_mant_d = shifted;
        out_lz_d   = s2_lz_q;
        out_zero_d = s2_zero_q;
      end
    end
  end

  // NOTE: state updates use <= so every stage sees the pre-edge value of its
  // predecessor; data registers are reset too so outputs read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_lz_q     <= '0;
      s2_zero_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_lz_q    <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_lz_q     <= s2_lz_d;
      s2_zero_q   <= s2_zero_d;
      out_valid_q <= out_valid_d;
      out_mant_q  <= out_mant_d;
      out_lz_q    <= out_lz_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mant  = out_mant_q;
  assign out_lz    = out_lz_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_lzd_normalizer.sv
// Directed and randomized checks of lzd_normalizer at DATA_W=32.
module tb_lzd_normalizer;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [31:0] in_data   = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_mant;
  logic [4:0]  out_lz;
  logic        out_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lzd_normalizer #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_lz    (out_lz),
    .out_zero  (out_zero)
  );

  // Reference: {zero, lz, mant} computed bit by bit.
  function automatic logic [37:0] ref_result(input logic [31:0] d);
    logic [4:0] lz;
    lz = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) lz = 5'(31 - i);
    end
    if (d == 32'd0) return {1'b1, 5'd0, 32'd0};
    return {1'b0, lz, d << lz};
  endfunction

  task automatic test_reset();
    #12;
    n_checks++;
    if ({out_valid, out_zero, out_lz, out_mant} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b zero=%0b lz=%0d mant=%h, expected all 0",
               out_valid, out_zero, out_lz, out_mant);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%0b out_valid=%0b, expected 1/0", in_ready, out_valid);
    end
  endtask

  // One sample through an empty pipe: out_valid rises on the third edge.
  task automatic test_single(input string name, input logic [31:0] d, input logic [37:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early1: got out_valid=%0b, expected 0", name, out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early2: got out_valid=%0b, expected 0", name, out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, out_zero, out_lz, out_mant} !== {1'b1, exp}) begin
      n_fail++;
      $display("FAIL %s_result: got valid=%0b zero=%0b lz=%0d mant=%h, expected 1 %0b %0d %h",
               name, out_valid, out_zero, out_lz, out_mant, exp[37], exp[36:32], exp[31:0]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: got out_valid=%0b, expected 0", name, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] din [3] = '{32'h8000_0000, 32'h00F0_0000, 32'h0001_2345};
    logic [37:0] exp [3] = '{{1'b0, 5'd0,  32'h8000_0000},
                             {1'b0, 5'd8,  32'hF000_0000},
                             {1'b0, 5'd15, 32'h91A2_8000}};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = din[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({out_valid, out_zero, out_lz, out_mant} !== {1'b1, exp[i]}) begin
        n_fail++;
        $display("FAIL b2b_out%0d: got valid=%0b zero=%0b lz=%0d mant=%h, expected 1 %0b %0d %h",
                 i, out_valid, out_zero, out_lz, out_mant, exp[i][37], exp[i][36:32], exp[i][31:0]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got out_valid=%0b, expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] din [6] = '{32'h0000_0001, 32'h4000_0000, 32'h0000_0300,
                             32'h1234_5678, 32'h0000_0000, 32'h00FF_FFFF};
    logic [37:0] exp [6] = '{{1'b0, 5'd31, 32'h8000_0000},
                             {1'b0, 5'd1,  32'h8000_0000},
                             {1'b0, 5'd22, 32'hC000_0000},
                             {1'b0, 5'd3,  32'h91A2_B3C0},
                             {1'b1, 5'd0,  32'h0000_0000},
                             {1'b0, 5'd8,  32'hFFFF_FF00}};
    logic [38:0] snap;
    int idx  = 0;
    int oidx = 0;
    int cyc  = 0;
    snap = '0;
    while (cyc < 40 && oidx < 6) begin
      @(posedge clk); #1;
      in_valid  = (idx < 6);
      in_data   = (idx < 6) ? din[idx] : 32'h0;
      out_ready = (cyc >= 5);
      @(negedge clk);
      if (cyc == 3) snap = {out_valid, out_zero, out_lz, out_mant};
      if (cyc == 4) begin
        n_checks++;
        if (idx !== 3 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_full: got accepted=%0d in_ready=%0b, expected 3/0", idx, in_ready);
        end
        n_checks++;
        if ({out_valid, out_zero, out_lz, out_mant} !== snap || snap !== {1'b1, exp[0]}) begin
          n_fail++;
          $display("FAIL bp_stall_hold: got %h (earlier %h), expected %h",
                   {out_valid, out_zero, out_lz, out_mant}, snap, {1'b1, exp[0]});
        end
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        n_checks++;
        if ({out_zero, out_lz, out_mant} !== exp[oidx]) begin
          n_fail++;
          $display("FAIL bp_out%0d: got zero=%0b lz=%0d mant=%h, expected %0b %0d %h",
                   oidx, out_zero, out_lz, out_mant, exp[oidx][37], exp[oidx][36:32], exp[oidx][31:0]);
        end
        oidx++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (oidx !== 6) begin
      n_fail++;
      $display("FAIL bp_count: got %0d outputs, expected 6", oidx);
    end
  endtask

  task automatic test_reset_mid_flight();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h0000_0010 << i;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got out_valid=%0b, expected 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_zero, out_lz, out_mant} !== 39'd0) begin
      n_fail++;
      $display("FAIL rst_async: got valid=%0b zero=%0b lz=%0d mant=%h, expected all 0",
               out_valid, out_zero, out_lz, out_mant);
    end
    @(posedge clk); #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_release: got in_ready=%0b out_valid=%0b, expected 1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_stale%0d: got out_valid=%0b, expected 0", i, out_valid);
      end
    end
    test_single("rst_after", 32'h00F0_0000, {1'b0, 5'd8, 32'hF000_0000});
  endtask

  task automatic test_random();
    logic [37:0] q[$];
    logic [38:0] held;
    logic [37:0] exp;
    bit          hold_chk = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 10040; cyc++) begin
      @(posedge clk); #1;
      if (hold_chk) begin
        n_checks++;
        if ({out_valid, out_zero, out_lz, out_mant} !== held) begin
          n_fail++;
          $display("FAIL rnd_hold: got %h, expected held %h", {out_valid, out_zero, out_lz, out_mant}, held);
        end
      end
      if (cyc < 10000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = $urandom >> $urandom_range(0, 32);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) q.push_back(ref_result(in_data));
      if (out_valid && out_ready) begin
        exp = (q.size() > 0) ? q.pop_front() : 38'h3F_FFFF_FFFF;
        n_checks++;
        if ({out_zero, out_lz, out_mant} !== exp) begin
          n_fail++;
          $display("FAIL rnd_out: got zero=%0b lz=%0d mant=%h, expected %0b %0d %h",
                   out_zero, out_lz, out_mant, exp[37], exp[36:32], exp[31:0]);
        end
      end
      hold_chk = out_valid && !out_ready;
      held     = {out_valid, out_zero, out_lz, out_mant};
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_drain: got %0d samples outstanding, expected 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single("single_lsb", 32'h0000_0001, {1'b0, 5'd31, 32'h8000_0000});
    test_back_to_back();
    test_single("zero_in", 32'h0000_0000, {1'b1, 5'd0, 32'h0000_0000});
    test_backpressure();
    test_reset_mid_flight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
